// File: rtl/dc_offset_rm_pkg.sv
// Shared constants, FSM state encoding and acquisition-length decode for the DC offset canceller.
package dc_offset_rm_pkg;

    localparam int unsigned D_WID    = 10;
    localparam int unsigned ACC_FRAC = 8;
    localparam int unsigned ACC_WID  = D_WID + ACC_FRAC;
    localparam int unsigned CNT_WID  = 9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAcq   = 2'd1,
        StTrack = 2'd2,
        StHold  = 2'd3
    } dcr_state_e;

    // Index of the final acquisition sample (length minus one).
    function automatic logic [CNT_WID-1:0] acq_last(input logic [1:0] len);
        logic [CNT_WID-1:0] last;
        case (len)
            2'd0:    last = 9'd63;
            2'd1:    last = 9'd127;
            2'd2:    last = 9'd255;
            default: last = 9'd511;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/dc_offset_rm_chan.sv
// One channel of the canceller: subtract the DC estimate, clip, and update the leaky integrator.
module dc_offset_rm_chan
    import dc_offset_rm_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [D_WID-1:0]  x_i,
    input  logic                     en_i,
    input  logic                     bypass_i,
    input  logic                     upd_i,
    input  logic                     clear_i,
    input  logic [2:0]               shift_i,
    output logic signed [D_WID-1:0]  y_o,
    output logic signed [D_WID-1:0]  est_o,
    output logic                     clip_o
);

    localparam logic signed [D_WID-1:0]   E_MAX = {1'b0, {(D_WID-1){1'b1}}};
    localparam logic signed [D_WID-1:0]   E_MIN = {1'b1, {(D_WID-1){1'b0}}};
    localparam logic signed [ACC_WID-1:0] A_MAX = {1'b0, {(ACC_WID-1){1'b1}}};
    localparam logic signed [ACC_WID-1:0] A_MIN = {1'b1, {(ACC_WID-1){1'b0}}};

    logic signed [ACC_WID-1:0] acc_q, acc_d, step, acc_sat;
    logic signed [ACC_WID:0]   sum;
    logic signed [D_WID:0]     diff;
    logic signed [D_WID-1:0]   err, y_q;

    assign est_o = acc_q[ACC_WID-1:ACC_FRAC];
    assign diff  = {x_i[D_WID-1], x_i} - {est_o[D_WID-1], est_o};

    always_comb begin
        clip_o = diff[D_WID] != diff[D_WID-1];
        if (!clip_o) begin
            err = diff[D_WID-1:0];
        end else if (diff[D_WID]) begin
            err = E_MIN;
        end else begin
            err = E_MAX;
        end
    end

    // Loop gain is 2^-k applied to the error scaled into accumulator units.
    assign step = $signed({err, {ACC_FRAC{1'b0}}}) >>> shift_i;
    assign sum  = {acc_q[ACC_WID-1], acc_q} + {step[ACC_WID-1], step};

    always_comb begin
        if (sum[ACC_WID] != sum[ACC_WID-1]) begin
            acc_sat = sum[ACC_WID] ? A_MIN : A_MAX;
        end else begin
            acc_sat = sum[ACC_WID-1:0];
        end
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (upd_i) begin
            acc_d = acc_sat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            if (en_i) begin
                y_q <= bypass_i ? x_i : err;
            end
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/dc_offset_rm.sv
// I/Q DC offset canceller top: acquisition/tracking FSM, ACQ counter and the two channel loops.
module dc_offset_rm
    import dc_offset_rm_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [D_WID-1:0] data_I_in,
    input  logic [D_WID-1:0] data_Q_in,
    input  logic             data_en,
    input  logic             dcr_en,
    input  logic             dc_restart,
    input  logic             dc_freeze,
    input  logic [1:0]       acq_len,
    input  logic [2:0]       acq_shift,
    input  logic [2:0]       trk_shift,
    output logic [D_WID-1:0] data_I_out,
    output logic [D_WID-1:0] data_Q_out,
    output logic             data_val_out,
    output logic [D_WID-1:0] dc_I_est,
    output logic [D_WID-1:0] dc_Q_est,
    output logic             dc_lock,
    output logic             sat_flag
);

    dcr_state_e         state_q, state_d;
    logic [CNT_WID-1:0] cnt_q, cnt_d;
    logic               val_q, sat_q;
    logic [2:0]         k_raw, k_eff;
    logic               bypass, upd, clip_i, clip_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!dcr_en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StAcq;
                    cnt_d   = '0;
                end
                StAcq: begin
                    if (dc_restart) begin
                        cnt_d = '0;
                    end else if (data_en) begin
                        // >= keeps a shortened acq_len mid-acquisition from wrapping the counter.
                        if (cnt_q >= acq_last(acq_len)) begin
                            state_d = dc_freeze ? StHold : StTrack;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StTrack: begin
                    if (dc_restart) begin
                        state_d = StAcq;
                        cnt_d   = '0;
                    end else if (dc_freeze) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (dc_restart) begin
                        state_d = StAcq;
                        cnt_d   = '0;
                    end else if (!dc_freeze) begin
                        state_d = StTrack;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            val_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= data_en;
            sat_q   <= data_en && !bypass && (clip_i || clip_q);
        end
    end

    assign k_raw  = (state_q == StAcq) ? acq_shift : trk_shift;
    assign k_eff  = (k_raw == 3'd0) ? 3'd1 : k_raw;
    assign bypass = state_q == StIdle;
    assign upd    = data_en && ((state_q == StAcq) || (state_q == StTrack));

    dc_offset_rm_chan u_chan_i (
        .clk      (clk),
        .reset_n  (reset_n),
        .x_i      (data_I_in),
        .en_i     (data_en),
        .bypass_i (bypass),
        .upd_i    (upd),
        .clear_i  (!dcr_en),
        .shift_i  (k_eff),
        .y_o      (data_I_out),
        .est_o    (dc_I_est),
        .clip_o   (clip_i)
    );

    dc_offset_rm_chan u_chan_q (
        .clk      (clk),
        .reset_n  (reset_n),
        .x_i      (data_Q_in),
        .en_i     (data_en),
        .bypass_i (bypass),
        .upd_i    (upd),
        .clear_i  (!dcr_en),
        .shift_i  (k_eff),
        .y_o      (data_Q_out),
        .est_o    (dc_Q_est),
        .clip_o   (clip_q)
    );

    assign data_val_out = val_q;
    assign sat_flag     = sat_q;
    assign dc_lock      = (state_q == StTrack) || (state_q == StHold);

endmodule

// File: tb/tb_dc_offset_rm.sv
// Scoreboard bench for dc_offset_rm: directed scenarios plus randomized traffic against an arithmetic model.
module tb_dc_offset_rm;

    localparam int DW = 10;
    localparam int MIDLE = 0, MACQ = 1, MTRACK = 2, MHOLD = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] data_I_in = '0, data_Q_in = '0;
    logic          data_en = 1'b0, dcr_en = 1'b0, dc_restart = 1'b0, dc_freeze = 1'b0;
    logic [1:0]    acq_len = '0;
    logic [2:0]    acq_shift = '0, trk_shift = '0;
    logic [DW-1:0] data_I_out, data_Q_out, dc_I_est, dc_Q_est;
    logic          data_val_out, dc_lock, sat_flag;

    dc_offset_rm dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_I_in    (data_I_in),
        .data_Q_in    (data_Q_in),
        .data_en      (data_en),
        .dcr_en       (dcr_en),
        .dc_restart   (dc_restart),
        .dc_freeze    (dc_freeze),
        .acq_len      (acq_len),
        .acq_shift    (acq_shift),
        .trk_shift    (trk_shift),
        .data_I_out   (data_I_out),
        .data_Q_out   (data_Q_out),
        .data_val_out (data_val_out),
        .dc_I_est     (dc_I_est),
        .dc_Q_est     (dc_Q_est),
        .dc_lock      (dc_lock),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
        bit sat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0, miscompares = 0;

    // Reference model: accumulators in 1/256 units, mode and count of acquisition samples.
    int m_mode = MIDLE, m_acc_i = 0, m_acc_q = 0, m_n = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int est_of(input int acc);
        return acc >>> 8;
    endfunction

    function automatic int sv(input logic [DW-1:0] x);
        return int'($signed(x));
    endfunction

    task automatic model_step();
        int   xi, xq, ri, rq, ei, eq, k;
        exp_t e;
        xi = sv(data_I_in);
        xq = sv(data_Q_in);
        if (data_en) begin
            if (m_mode == MIDLE) begin
                e.i = xi; e.q = xq; e.sat = 1'b0;
            end else begin
                ri = xi - est_of(m_acc_i);
                rq = xq - est_of(m_acc_q);
                ei = clamp(ri, -512, 511);
                eq = clamp(rq, -512, 511);
                e.i = ei; e.q = eq; e.sat = (ei != ri) || (eq != rq);
                if (m_mode == MACQ || m_mode == MTRACK) begin
                    k = (m_mode == MACQ) ? int'(acq_shift) : int'(trk_shift);
                    if (k == 0) k = 1;
                    m_acc_i = clamp(m_acc_i + ((ei * 256) >>> k), -(1 << 17), (1 << 17) - 1);
                    m_acc_q = clamp(m_acc_q + ((eq * 256) >>> k), -(1 << 17), (1 << 17) - 1);
                end
            end
            sb.push_back(e);
        end
        if (!dcr_en) begin
            m_mode = MIDLE; m_acc_i = 0; m_acc_q = 0; m_n = 0;
        end else if (m_mode == MIDLE) begin
            m_mode = MACQ; m_n = 0;
        end else if (dc_restart) begin
            m_mode = MACQ; m_n = 0;
        end else if (m_mode == MACQ) begin
            if (data_en) begin
                m_n++;
                if (m_n >= (64 << acq_len)) begin
                    m_mode = dc_freeze ? MHOLD : MTRACK;
                    m_n = 0;
                end
            end
        end else if (m_mode == MTRACK && dc_freeze) begin
            m_mode = MHOLD;
        end else if (m_mode == MHOLD && !dc_freeze) begin
            m_mode = MTRACK;
        end
    endtask

    task automatic drive(input int xi, input int xq, input bit en);
        data_I_in = xi[DW-1:0];
        data_Q_in = xq[DW-1:0];
        data_en   = en;
        model_step();
        @(posedge clk);
        #1;
        dc_restart = 1'b0;
        chk("data_val_out", int'(data_val_out), int'(en));
        chk("dc_lock", int'(dc_lock), int'(m_mode == MTRACK || m_mode == MHOLD));
        chk("dc_I_est", sv(dc_I_est), est_of(m_acc_i));
        chk("dc_Q_est", sv(dc_Q_est), est_of(m_acc_q));
        if (!en) chk("sat_flag_idle", int'(sat_flag), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        sb.delete();
        m_mode = MIDLE; m_acc_i = 0; m_acc_q = 0; m_n = 0;
        chk("rst_I_out", sv(data_I_out), 0);
        chk("rst_Q_out", sv(data_Q_out), 0);
        chk("rst_val", int'(data_val_out), 0);
        chk("rst_I_est", sv(dc_I_est), 0);
        chk("rst_Q_est", sv(dc_Q_est), 0);
        chk("rst_lock", int'(dc_lock), 0);
        chk("rst_sat", int'(sat_flag), 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_n && data_val_out) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_underflow: output seen, none expected (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_I_out", sv(data_I_out), mon_e.i);
                chk("sb_Q_out", sv(data_Q_out), mon_e.q);
                chk("sb_sat", int'(sat_flag), int'(mon_e.sat));
            end
        end
    end

    initial begin
        int off_i, off_q;

        // Reset and bypass
        do_reset();
        for (int c = 0; c < 5; c++) drive(37, -5, 1'b1);
        chk("bypass_I", sv(data_I_out), 37);
        chk("bypass_Q", sv(data_Q_out), -5);

        // Acquisition on constant offset
        dcr_en = 1'b1; acq_len = 2'd0; acq_shift = 3'd2; trk_shift = 3'd2;
        drive(0, 0, 1'b0);
        for (int s = 0; s < 30; s++) drive(40, -24, 1'b1);
        chk("acq_I_est", sv(dc_I_est), 40);
        chk("acq_Q_est", sv(dc_Q_est), -24);
        chk("acq_I_small", int'(sv(data_I_out) >= -1 && sv(data_I_out) <= 1), 1);
        chk("acq_Q_small", int'(sv(data_Q_out) >= -1 && sv(data_Q_out) <= 1), 1);
        for (int s = 30; s < 63; s++) drive(40, -24, 1'b1);
        chk("lock_before_64", int'(dc_lock), 0);
        drive(40, -24, 1'b1);
        chk("lock_at_64", int'(dc_lock), 1);

        // Freeze, step, release
        dc_freeze = 1'b1;
        drive(40, -24, 1'b1);
        for (int s = 0; s < 5; s++) drive(100, -24, 1'b1);
        chk("freeze_I_est", sv(dc_I_est), 40);
        chk("freeze_I_out", sv(data_I_out), 60);
        dc_freeze = 1'b0;
        for (int s = 0; s < 60; s++) drive(100, -24, 1'b1);
        chk("release_I_est", sv(dc_I_est), 100);

        // Negative clip
        drive(-512, -24, 1'b1);
        chk("clip_I_out", sv(data_I_out), -512);
        chk("clip_sat", int'(sat_flag), 1);
        drive(0, -24, 1'b0);
        chk("clip_sat_pulse", int'(sat_flag), 0);

        // Sparse strobes during acquisition
        dcr_en = 1'b0;
        drive(0, 0, 1'b0);
        dcr_en = 1'b1; acq_shift = 3'd3;
        drive(0, 0, 1'b0);
        for (int s = 0; s < 64; s++) begin
            drive(40, -24, 1'b1);
            if (s == 62) chk("sparse_lock_63", int'(dc_lock), 0);
            if (s < 63) for (int g = 0; g < 3; g++) drive(40, -24, 1'b0);
        end
        chk("sparse_lock_64", int'(dc_lock), 1);

        // Reset mid-acquisition, then restart from track
        dc_restart = 1'b1;
        drive(40, -24, 1'b0);
        chk("restart_unlock", int'(dc_lock), 0);
        for (int s = 0; s < 10; s++) drive(40, -24, 1'b1);
        do_reset();
        acq_shift = 3'd2;
        drive(0, 0, 1'b0);
        for (int s = 0; s < 64; s++) drive(40, -24, 1'b1);
        chk("relock", int'(dc_lock), 1);
        dc_restart = 1'b1;
        drive(40, -24, 1'b0);
        chk("trk_restart_lock", int'(dc_lock), 0);
        chk("trk_restart_est", sv(dc_I_est), 40);

        // Randomized traffic
        off_i = 0; off_q = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                acq_len   = 2'($urandom_range(0, 3));
                acq_shift = 3'($urandom_range(0, 7));
                trk_shift = 3'($urandom_range(0, 7));
                off_i = $urandom_range(0, 600) - 300;
                off_q = $urandom_range(0, 600) - 300;
            end
            dcr_en = ($urandom_range(0, 299) != 0);
            dc_restart = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) dc_freeze = ~dc_freeze;
            if ($urandom_range(0, 29) == 0) begin
                drive($urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512,
                      ($urandom_range(0, 3) != 0));
            end else begin
                drive(clamp(off_i + $urandom_range(0, 16) - 8, -512, 511),
                      clamp(off_q + $urandom_range(0, 16) - 8, -512, 511),
                      ($urandom_range(0, 3) != 0));
            end
        end

        drive(0, 0, 1'b0);
        drive(0, 0, 1'b0);
        chk("scoreboard_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
